// File: rtl/mic_decimator.sv
// Block-average decimator for a signed I2S microphone stream: sums D = 2^LOG2_DECIM samples
// and emits sum/D through a one-entry valid/ready output register. Define MIC_DECIM_ROUND_EN for round-half-up.
module mic_decimator #(
  parameter int SAMPLE_W   = 24,
  parameter int LOG2_DECIM = 2
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid_in,
  input  logic                sync_in,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready_in,
  output logic                overflow_out,
  output logic                overflow_sticky_out
);
  localparam int ACC_W = SAMPLE_W + LOG2_DECIM + 1;

  logic signed [ACC_W-1:0] acc, acc_nxt, sample_ext, sum, rsum, shifted;
  logic [LOG2_DECIM-1:0]   cnt, cnt_nxt;
  logic [SAMPLE_W-1:0]     result;
  logic                    done, load, drop, unused_bits;

  assign sample_ext = {{(LOG2_DECIM+1){sample_in[SAMPLE_W-1]}}, sample_in};
  assign sum        = acc + sample_ext;

`ifdef MIC_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (LOG2_DECIM-1);
  assign rsum = sum + RND;
`else
  assign rsum = sum;
`endif

  // The extra guard bit keeps full-scale positive input plus rounding from wrapping.
  assign shifted     = rsum >>> LOG2_DECIM;
  assign result      = shifted[SAMPLE_W-1:0];
  assign unused_bits = ^shifted[ACC_W-1:SAMPLE_W];

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    done    = 1'b0;
    if (sample_valid_in) begin
      if (sync_in) begin
        acc_nxt = sample_ext;
        cnt_nxt = LOG2_DECIM'(1);
      end else if (cnt == '1) begin
        done    = 1'b1;
        acc_nxt = '0;
        cnt_nxt = '0;
      end else begin
        acc_nxt = sum;
        cnt_nxt = cnt + LOG2_DECIM'(1);
      end
    end else if (sync_in) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end
  end

  // A completed result may replace the held one only if it is being consumed this cycle.
  assign load = done && (!out_valid || out_ready_in);
  assign drop = done && out_valid && !out_ready_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      out_data            <= '0;
      out_valid           <= 1'b0;
      overflow_out        <= 1'b0;
      overflow_sticky_out <= 1'b0;
    end else begin
      if (load) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready_in) begin
        out_valid <= 1'b0;
      end
      overflow_out        <= drop;
      overflow_sticky_out <= overflow_sticky_out | drop;
    end
  end
endmodule

// File: tb/tb_mic_decimator.sv
// Scoreboard bench for mic_decimator: a block-average reference model queues expected results,
// a negedge monitor pops and compares on each handshake.
module tb_mic_decimator;
  localparam int SW = 24;
  localparam int L  = 2;
  localparam int D  = 4;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic [SW-1:0] sample_in;
  logic          sample_valid_in, sync_in, out_ready_in;
  logic [SW-1:0] out_data;
  logic          out_valid, overflow_out, overflow_sticky_out;

  mic_decimator #(.SAMPLE_W(SW), .LOG2_DECIM(L)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .sample_in(sample_in),
    .sample_valid_in(sample_valid_in), .sync_in(sync_in), .out_data(out_data),
    .out_valid(out_valid), .out_ready_in(out_ready_in), .overflow_out(overflow_out),
    .overflow_sticky_out(overflow_sticky_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0, errors = 0, hs_cnt = 0;
  logic signed [63:0] exp_q[$];
  logic signed [63:0] blk[$];
  logic signed [63:0] last_pop = 0;
  bit ev_cur, ev_nxt, eo_cur, eo_nxt, es_cur, es_nxt, mon_en;

  task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // Mean of a block: floor(sum/D), or floor((sum + D/2)/D) when rounding is built in.
  function automatic logic signed [63:0] block_result(input logic signed [63:0] s[$]);
    logic signed [63:0] total = 0, q;
    foreach (s[i]) total += s[i];
`ifdef MIC_DECIM_ROUND_EN
    total += D / 2;
`endif
    q = total / D;
    if ((total % D) != 0 && total < 0) q -= 1;
    return q;
  endfunction

  task automatic step(input bit v, input logic [SW-1:0] s, input bit sy, input bit rdy);
    bit done = 0;
    logic signed [63:0] res = 0;
    @(posedge clk_in); #1;
    ev_cur = ev_nxt; eo_cur = eo_nxt; es_cur = es_nxt;
    sample_valid_in = v; sample_in = s; sync_in = sy; out_ready_in = rdy;
    if (v) begin
      if (sy) blk.delete();
      blk.push_back(64'($signed(s)));
      if (blk.size() == D) begin
        res = block_result(blk);
        blk.delete();
        done = 1;
      end
    end else if (sy) blk.delete();
    eo_nxt = 0;
    if (done && ev_cur && !rdy) begin
      eo_nxt = 1; es_nxt = 1; ev_nxt = 1;
    end else if (done) begin
      exp_q.push_back(res); ev_nxt = 1;
    end else ev_nxt = ev_cur && !rdy;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, '0, 0, rdy);
  endtask

  task automatic clear_model();
    blk.delete(); exp_q.delete();
    ev_cur = 0; ev_nxt = 0; eo_cur = 0; eo_nxt = 0; es_cur = 0; es_nxt = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_overflow"}, overflow_out, 0);
    chk({tag, "_sticky"}, overflow_sticky_out, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_in); #1;
    rst_n_in = 0; sample_valid_in = 0; sync_in = 0;
    #2;
    check_reset_outputs("async_reset");
    clear_model();
    @(posedge clk_in); #1;
    rst_n_in = 1;
  endtask

  always @(negedge clk_in) begin
    if (mon_en) begin
      chk("out_valid", out_valid, ev_cur);
      chk("overflow_out", overflow_out, eo_cur);
      chk("overflow_sticky", overflow_sticky_out, es_cur);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_data got %0d expected no result", $signed(out_data));
        end else begin
          chk("out_data", 64'($signed(out_data)), exp_q[0]);
          if (out_ready_in) begin
            last_pop = exp_q.pop_front();
            hs_cnt++;
          end
        end
      end
    end
  end

  initial begin
    int hs0;
    logic [SW-1:0] s;
    rst_n_in = 1; sample_in = '0; sample_valid_in = 0; sync_in = 0; out_ready_in = 0;
    clear_model();
    #3 rst_n_in = 0;
    #2 check_reset_outputs("reset");
    mon_en = 1;
    @(posedge clk_in); #1 rst_n_in = 1;

    // 1,2,3,4 -> 2 (floor) / 3 (round)
    step(1, 24'd1, 0, 1); step(1, 24'd2, 0, 1); step(1, 24'd3, 0, 1); step(1, 24'd4, 0, 1);
    idle(2, 1);
`ifdef MIC_DECIM_ROUND_EN
    chk("ramp_result", last_pop, 3);
`else
    chk("ramp_result", last_pop, 2);
`endif

    // -1,-1,-1,-2 -> -2 (floor) / -1 (round)
    step(1, 24'hFFFFFF, 0, 1); step(1, 24'hFFFFFF, 0, 1);
    step(1, 24'hFFFFFF, 0, 1); step(1, 24'hFFFFFE, 0, 1);
    idle(2, 1);
`ifdef MIC_DECIM_ROUND_EN
    chk("neg_result", last_pop, -1);
`else
    chk("neg_result", last_pop, -2);
`endif

    // full-scale positive, back to back
    for (int i = 0; i < 8; i++) step(1, 24'h7FFFFF, 0, 1);
    idle(2, 1);
    chk("fullscale_result", last_pop, 64'sh7FFFFF);

    // two blocks while stalled: second dropped, first survives
    for (int i = 0; i < 4; i++) step(1, 24'd10, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 24'd20, 0, 0);
    idle(3, 0);
    hs0 = hs_cnt;
    idle(3, 1);
    chk("stall_handshakes", hs_cnt - hs0, 1);
    chk("stall_result", last_pop, 10);
    chk("stall_sticky", overflow_sticky_out, 1);

    // sync with sample restarts the block
    step(1, 24'd5, 0, 1); step(1, 24'd5, 0, 1);
    step(1, 24'd8, 1, 1); step(1, 24'd8, 0, 1); step(1, 24'd8, 0, 1); step(1, 24'd8, 0, 1);
    idle(2, 1);
    chk("sync_result", last_pop, 8);

    // reset mid-block
    step(1, 24'd3, 0, 1); step(1, 24'd3, 0, 1); step(1, 24'd3, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 24'd7, 0, 1);
    idle(2, 1);
    chk("post_reset_result", last_pop, 7);

    // randomized traffic, with sync strobes, stalls and extreme values
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 5))
        0: s = 24'h7FFFFF;
        1: s = 24'h800000;
        default: s = SW'($urandom);
      endcase
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
    end
    idle(10, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
